// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: synchronise, optionally glitch-filter, decode to detent pulses.
// Define QDEC_GLITCH_FILTER_EN to build the FILT_LEN-cycle stability filter on the AB pair.
module quadrature_decoder #(
   parameter int SYNC_STAGES     = 2,
   parameter int FILT_LEN        = 4,
   parameter int STEPS_PER_PULSE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enc_a,
   input  logic enc_b,
   input  logic error_clr,
   output logic increment,
   output logic decrement,
   output logic error
);

   localparam int AW = $clog2(STEPS_PER_PULSE) + 2;
   localparam logic signed [AW-1:0] ACC_MAX = AW'(STEPS_PER_PULSE - 1);
   localparam logic signed [AW-1:0] ACC_MIN = -ACC_MAX;
   localparam logic signed [AW-1:0] ACC_ONE = AW'(1);

   // The init window covers the synchroniser (and filter) flushing their post-reset
   // zeros, so whatever resting state the pins hold is absorbed instead of decoded.
   localparam int INIT_CYCLES = SYNC_STAGES + FILT_LEN + 1;
   localparam int IW          = $clog2(INIT_CYCLES + 1);

   logic [SYNC_STAGES-1:0] r_sync_a;
   logic [SYNC_STAGES-1:0] r_sync_b;
   logic [1:0]             w_ab_s;
   logic [1:0]             w_ab_f;
   logic [1:0]             r_prev_ab;
   logic                   r_init;
   logic [IW-1:0]          r_init_cnt;
   logic signed [AW-1:0]   r_acc;
   logic                   r_inc;
   logic                   r_dec;
   logic                   r_error;
   logic                   w_step_up;
   logic                   w_step_dn;
   logic                   w_illegal;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync_a <= '0;
         r_sync_b <= '0;
      end else begin
         r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], enc_a};
         r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], enc_b};
      end
   end

   assign w_ab_s = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};

`ifdef QDEC_GLITCH_FILTER_EN
   localparam int CW = $clog2(FILT_LEN + 1);

   logic [1:0]    r_ab_f;
   logic [1:0]    r_cand;
   logic [CW-1:0] r_filt_cnt;
   logic [CW-1:0] w_run;

   // Length of the current run of identical samples, including this cycle's.
   assign w_run = (w_ab_s == r_cand) ? r_filt_cnt + 1'b1 : CW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ab_f     <= '0;
         r_cand     <= '0;
         r_filt_cnt <= '0;
      end else begin
         r_cand <= w_ab_s;
         if (w_ab_s == r_ab_f) begin
            r_filt_cnt <= '0;
         end else if (w_run >= CW'(FILT_LEN)) begin
            r_ab_f     <= w_ab_s;
            r_filt_cnt <= '0;
         end else begin
            r_filt_cnt <= w_run;
         end
      end
   end

   assign w_ab_f = r_ab_f;
`else
   assign w_ab_f = w_ab_s;
`endif

   // NOTE: defaults first so no path through always_comb leaves an output unassigned (no latch).
   always_comb begin
      w_step_up = 1'b0;
      w_step_dn = 1'b0;
      w_illegal = 1'b0;
      case ({r_prev_ab, w_ab_f})
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_step_up = 1'b1;
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_step_dn = 1'b1;
         4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: w_illegal = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev_ab  <= '0;
         r_init     <= 1'b0;
         r_init_cnt <= '0;
         r_acc      <= '0;
         r_inc      <= 1'b0;
         r_dec      <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_prev_ab <= w_ab_f;
         r_inc     <= 1'b0;
         r_dec     <= 1'b0;
         // Set has priority over clear when both land in one cycle.
         r_error   <= (r_init & w_illegal) | (r_error & ~error_clr);
         if (!r_init) begin
            if (r_init_cnt == IW'(INIT_CYCLES - 1)) r_init <= 1'b1;
            else                                     r_init_cnt <= r_init_cnt + 1'b1;
         end else if (w_step_up) begin
            if (r_acc == ACC_MAX) begin
               r_acc <= '0;
               r_inc <= 1'b1;
            end else begin
               r_acc <= r_acc + ACC_ONE;
            end
         end else if (w_step_dn) begin
            if (r_acc == ACC_MIN) begin
               r_acc <= '0;
               r_dec <= 1'b1;
            end else begin
               r_acc <= r_acc - ACC_ONE;
            end
         end
      end
   end

   assign increment = r_inc;
   assign decrement = r_dec;
   assign error     = r_error;

endmodule
